// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : aes_pkg
//  Purpose  : AES-128 constants and byte/word helpers shared by the CBC engine.
//  Revision : 1.0
// ============================================================================
package aes_pkg;

   localparam int NR    = 10;
   localparam int BLK_W = 128;

   // Entries 0 and 11..15 are never used by AES-128 but keep a 4-bit index safe.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // State is column-major: byte (row + 4*col) sits at bits [127-8*(row+4*col) -: 8].
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int col = 0; col < 4; col++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_enc_round.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_enc_round
//  Purpose  : One combinational AES encryption round; MixColumns bypassed on the last round.
//  Revision : 1.0
// ============================================================================
module aes128_enc_round
   import aes_pkg::*;
(
   input  logic [BLK_W-1:0] state_in,
   input  logic [BLK_W-1:0] rk_next,
   input  logic             last,
   output logic [BLK_W-1:0] state_out
);

   logic [BLK_W-1:0] sub_bytes;
   logic [BLK_W-1:0] shifted;
   logic [BLK_W-1:0] mixed;

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign sub_bytes[BLK_W-1-32*gi -: 32] = sub_word(state_in[BLK_W-1-32*gi -: 32]);
      assign mixed[BLK_W-1-32*gi -: 32]     = mix_column(shifted[BLK_W-1-32*gi -: 32]);
   end

   assign shifted   = shift_rows(sub_bytes);
   assign state_out = (last ? shifted : mixed) ^ rk_next;

endmodule
`default_nettype wire

// File: rtl/cbc_encrypt_engine.sv
`default_nettype none
// ============================================================================
//  Module   : cbc_encrypt_engine
//  Purpose  : Iterative AES-128 CBC encryptor, one round per clock, valid/ready on both sides.
//  Revision : 1.0
// ============================================================================
module cbc_encrypt_engine
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [BLK_W-1:0] key,
   input  logic [BLK_W-1:0] iv,
   input  logic             cfg_load,
   input  logic [BLK_W-1:0] pt_data,
   input  logic             pt_valid,
   output logic             pt_ready,
   output logic [BLK_W-1:0] ct_data,
   output logic             ct_valid,
   input  logic             ct_ready,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   logic [1:0]       fsm_q, fsm_d;
   logic [BLK_W-1:0] state_q, state_d;
   logic [BLK_W-1:0] rk_q, rk_d;
   logic [BLK_W-1:0] key_reg_q, key_reg_d;
   logic [BLK_W-1:0] chain_q, chain_d;
   logic [BLK_W-1:0] ct_data_q, ct_data_d;
   logic [3:0]       rnd_cnt_q, rnd_cnt_d;

   logic [BLK_W-1:0] rk_next;
   logic [BLK_W-1:0] round_out;
   logic [31:0]      ks_t, nw0, nw1, nw2, nw3;
   logic             last_round;
   logic             take_block;

   assign last_round = (rnd_cnt_q == 4'(NR));
   assign take_block = (fsm_q == ST_IDLE) && pt_valid && !cfg_load;

   assign pt_ready = (fsm_q == ST_IDLE) && !cfg_load && !rst;
   assign ct_valid = (fsm_q == ST_HOLD);
   assign busy     = (fsm_q != ST_IDLE);
   assign ct_data  = ct_data_q;

   // On-the-fly key expansion: round key r+1 from round key r.
   always_comb begin
      ks_t = sub_word(rot_word(rk_q[31:0])) ^ {RCON[rnd_cnt_q], 24'h000000};
      nw0  = rk_q[127:96] ^ ks_t;
      nw1  = rk_q[95:64]  ^ nw0;
      nw2  = rk_q[63:32]  ^ nw1;
      nw3  = rk_q[31:0]   ^ nw2;
   end
   assign rk_next = {nw0, nw1, nw2, nw3};

   aes128_enc_round u_round (
      .state_in  (state_q),
      .rk_next   (rk_next),
      .last      (last_round),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d     = fsm_q;
      state_d   = state_q;
      rk_d      = rk_q;
      key_reg_d = key_reg_q;
      chain_d   = chain_q;
      ct_data_d = ct_data_q;
      rnd_cnt_d = rnd_cnt_q;
      case (fsm_q)
         ST_IDLE: begin
            if (cfg_load) begin
               key_reg_d = key;
               chain_d   = iv;
            end else if (take_block) begin
               state_d   = pt_data ^ chain_q ^ key_reg_q;
               rk_d      = key_reg_q;
               rnd_cnt_d = 4'd1;
               fsm_d     = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_d   = round_out;
            rk_d      = rk_next;
            rnd_cnt_d = rnd_cnt_q + 4'd1;
            if (last_round) begin
               // Chain is captured here so a stalled sink cannot disturb it.
               ct_data_d = round_out;
               chain_d   = round_out;
               fsm_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ct_ready) begin
               fsm_d = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q     <= ST_IDLE;
         state_q   <= '0;
         rk_q      <= '0;
         key_reg_q <= '0;
         chain_q   <= '0;
         ct_data_q <= '0;
         rnd_cnt_q <= '0;
      end else begin
         fsm_q     <= fsm_d;
         state_q   <= state_d;
         rk_q      <= rk_d;
         key_reg_q <= key_reg_d;
         chain_q   <= chain_d;
         ct_data_q <= ct_data_d;
         rnd_cnt_q <= rnd_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cbc_encrypt_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbc_encrypt_engine
//  Purpose  : Scoreboard bench for cbc_encrypt_engine against an independent AES model.
//  Revision : 1.0
// ============================================================================
module tb_cbc_encrypt_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key, iv, pt_data;
   logic         cfg_load, pt_valid, ct_ready;
   logic         pt_ready, ct_valid, busy;
   logic [127:0] ct_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [127:0] exp_q [$];
   logic [127:0] key_m, chain_m;
   logic [7:0]   tsbox [256];
   bit           spacing_chk = 0;
   bit           rand_ready  = 0;

   cbc_encrypt_engine dut (
      .clk      (clk),
      .rst      (rst),
      .key      (key),
      .iv       (iv),
      .cfg_load (cfg_load),
      .pt_data  (pt_data),
      .pt_valid (pt_valid),
      .pt_ready (pt_ready),
      .ct_data  (ct_data),
      .ct_valid (ct_valid),
      .ct_ready (ct_ready),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 ct_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- reference AES, from field arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p ^= aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [127:0] out;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {tsbox[tmp[31:24]], tsbox[tmp[23:16]], tsbox[tmp[15:8]], tsbox[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int j = 0; j < 16; j++) begin
         tmp  = w[j/4];
         s[j] = p[127-8*j -: 8] ^ tmp[31-8*(j%4) -: 8];
      end
      for (int r = 1; r <= 10; r++) begin
         for (int j = 0; j < 16; j++) s[j] = tsbox[s[j]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[q+4*c] = s[q+4*((c+q)%4)];
         for (int c = 0; c < 4; c++) begin
            if (r < 10) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
            end
         end
         for (int j = 0; j < 16; j++) begin
            tmp  = w[4*r + j/4];
            s[j] = s[j] ^ tmp[31-8*(j%4) -: 8];
         end
      end
      out = '0;
      for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
      return out;
   endfunction

   // ---------------- check helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int  acc_cyc  = -1;
   int  prev_acc = -1;
   logic ctv_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         acc_cyc  = -1;
         prev_acc = -1;
         ctv_prev = 1'b0;
      end else begin
         if (ct_valid && !ctv_prev) begin
            checks++;
            if (acc_cyc < 0 || cyc - acc_cyc != 11) begin
               errors++;
               $display("FAIL latency: got %0d clocks after accept, expected 11", cyc - acc_cyc);
            end
            acc_cyc = -1;
         end
         if (ct_valid && ct_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ct: got %h with nothing pending, expected no output", ct_data);
            end else begin
               check("ct_data", ct_data, exp_q.pop_front());
            end
         end
         if (!spacing_chk) prev_acc = -1;
         if (pt_valid && pt_ready) begin
            if (prev_acc >= 0) begin
               checks++;
               if (cyc - prev_acc != 12) begin
                  errors++;
                  $display("FAIL accept_spacing: got %0d clocks, expected 12", cyc - prev_acc);
               end
            end
            if (spacing_chk) prev_acc = cyc;
            acc_cyc = cyc;
         end
         ctv_prev = ct_valid;
      end
   end

   // ---------------- stimulus tasks ----------------
   // mode 0: expect model result, 1: expect kat, 2: no output expected
   task automatic send(input logic [127:0] pt, input int mode, input logic [127:0] kat);
      logic [127:0] e;
      int n;
      n = 0;
      pt_data  = pt;
      pt_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (pt_ready) break;
         n++;
         if (n > 2000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pt_ready stayed 0 for %0d clocks, expected 1", n);
            pt_valid = 1'b0;
            return;
         end
      end
      if (mode != 2) begin
         e = (mode == 1) ? kat : aes_model(key_m, pt ^ chain_m);
         chain_m = e;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      pt_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) break;
         n++;
         if (n > 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d, expected idle with 0 pending", busy, exp_q.size());
            exp_q.delete();
            break;
         end
      end
   endtask

   task automatic cfg(input logic [127:0] k, input logic [127:0] v);
      @(posedge clk);
      #1;
      pt_valid = 1'b0;
      key      = k;
      iv       = v;
      cfg_load = 1'b1;
      #1 check1("pt_ready_during_cfg", pt_ready, 1'b0);
      @(posedge clk);
      #1 cfg_load = 1'b0;
      key_m   = k;
      chain_m = v;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- main sequence ----------------
   logic [127:0] k1, pt_c1, ct_c1, k2, iv2, p1, p2, c1, c2;
   logic [7:0]   inv, xb, yb;

   initial begin
      for (int x = 0; x < 256; x++) begin
         xb  = 8'(x);
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            yb = 8'(y);
            if (gmul(xb, yb) == 8'h01) inv = yb;
         end
         tsbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      k1    = 128'h000102030405060708090a0b0c0d0e0f;
      pt_c1 = 128'h00112233445566778899aabbccddeeff;
      ct_c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      k2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      iv2   = 128'h000102030405060708090a0b0c0d0e0f;
      p1    = 128'h6bc1bee22e409f96e93d7e117393172a;
      c1    = 128'h7649abac8119b246cee98e9b12e9197d;
      p2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      c2    = 128'h5086cb9b507219ee95db113a917678b2;

      rst = 1'b1; key = '0; iv = '0; cfg_load = 1'b0;
      pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b1;
      key_m = '0; chain_m = '0;
      #1;
      check1("reset_ct_valid", ct_valid, 1'b0);
      check1("reset_pt_ready", pt_ready, 1'b0);
      check1("reset_busy", busy, 1'b0);
      check("reset_ct_data", ct_data, 128'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1 check1("idle_pt_ready", pt_ready, 1'b1);

      // FIPS-197 single block
      cfg(k1, 128'h0);
      send(pt_c1, 1, ct_c1);
      wait_idle();

      // SP800-38A two chained blocks
      cfg(k2, iv2);
      send(p1, 1, c1);
      send(p2, 1, c2);
      wait_idle();

      // Backpressure held for 20 clocks in HOLD
      cfg(k2, iv2);
      ct_ready = 1'b0;
      send(p1, 1, c1);
      pt_data = p2;
      for (int n = 0; n < 100 && !ct_valid; n++) @(negedge clk);
      check1("hold_reached", ct_valid, 1'b1);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         check("hold_ct_stable", ct_data, c1);
         check1("hold_pt_ready", pt_ready, 1'b0);
         check1("hold_ct_valid", ct_valid, 1'b1);
      end
      @(posedge clk);
      #1 ct_ready = 1'b1;
      send(p2, 1, c2);
      wait_idle();

      // Back-to-back throughput with random data
      cfg(rand128(), rand128());
      spacing_chk = 1;
      for (int b = 0; b < 4; b++) send(rand128(), 0, '0);
      wait_idle();
      spacing_chk = 0;

      // Reset mid-block at rnd_cnt=5
      cfg(k2, iv2);
      send(p1, 2, '0);
      pt_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 check1("busy_in_round", busy, 1'b1);
      rst = 1'b1;
      #1;
      check1("midrst_ct_valid", ct_valid, 1'b0);
      check1("midrst_pt_ready", pt_ready, 1'b0);
      check1("midrst_busy", busy, 1'b0);
      check("midrst_ct_data", ct_data, 128'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cfg(k2, iv2);
      send(p1, 1, c1);
      wait_idle();

      // cfg_load during ROUND must be ignored
      cfg(k1, 128'h0);
      send(pt_c1, 1, ct_c1);
      pt_valid = 1'b0;
      key      = rand128();
      iv       = rand128();
      cfg_load = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check1("cfg_in_round_pt_ready", pt_ready, 1'b0);
      end
      @(posedge clk);
      #1 cfg_load = 1'b0;
      wait_idle();
      cfg(k1, 128'h0);
      send(pt_c1, 1, ct_c1);
      wait_idle();

      // Random chains under random sink backpressure
      rand_ready = 1;
      for (int g = 0; g < 3; g++) begin
         cfg(rand128(), rand128());
         for (int b = 0; b < 3; b++) send(rand128(), 0, '0);
         wait_idle();
      end
      rand_ready = 0;
      @(posedge clk);
      #1 ct_ready = 1'b1;

      repeat (5) @(negedge clk);
      check("pending_at_end", 128'(exp_q.size()), 128'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
